// File: rtl/sound_dsp_rec_if.sv
// ISA DMA write handshake between the recording path (master) and the DMA controller (slave).
interface sound_dsp_rec_if;
    logic        dma_req8;
    logic        dma_req16;
    logic        dma_ack;
    logic [15:0] dma_writedata;

    modport master (
        output dma_req8,
        output dma_req16,
        output dma_writedata,
        input  dma_ack
    );

    modport slave (
        input  dma_req8,
        input  dma_req16,
        input  dma_writedata,
        output dma_ack
    );
endinterface

// File: rtl/sound_dsp_rec.sv
// Sound Blaster DSP recording path: rate-ticked capture, sample FIFO, DMA write handshake, block IRQ.
// Optional macro SOUND_REC_ROUND_EN selects rounding (with saturation) for the 8-bit conversion.
module sound_dsp_rec #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [27:0]            clock_rate,
    input  logic                   rec_start,
    input  logic                   rec_stop,
    input  logic                   rec_16bit,
    input  logic                   rec_stereo,
    input  logic                   rec_auto,
    input  logic [15:0]            rec_rate,
    input  logic [15:0]            rec_len,
    input  logic [15:0]            in_l,
    input  logic [15:0]            in_r,
    sound_dsp_rec_if.master        dma,
    output logic                   irq,
    input  logic                   irq_ack,
    output logic                   busy,
    output logic                   overrun
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = 29;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

    state_t          state, state_next;
    logic [SW-1:0]   sum, sum_add;
    logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [LW-1:0]   level;
    logic [15:0]     count, lat_len;
    logic            lat_16bit, lat_stereo, lat_auto;
    logic            pend_r;
    logic [15:0]     hold_r;

    logic            tick_c, pop_c, push_req_c, push_c, drop_c;
    logic            flush_c, arm_c, blk_end_c, req_c;
    logic [DW-1:0]   push_data_c;
    logic [LW-1:0]   avail_c;

    // Signed 16-bit sample to offset-binary byte
    function automatic logic [7:0] to_u8(input logic [15:0] s);
`ifdef SOUND_REC_ROUND_EN
        logic [15:0] t;
        t = s + 16'h0080;
        if (!s[15] && t[15]) t = 16'h7FFF;
        return t[15:8] ^ 8'h80;
`else
        return s[15:8] ^ 8'h80;
`endif
    endfunction

    function automatic logic [DW-1:0] fmt(input logic [15:0] s, input logic b16);
        return b16 ? s : {8'h00, to_u8(s)};
    endfunction

    assign sum_add = sum + SW'(rec_rate);
    assign tick_c  = (state == S_RUN) && (rec_rate != 16'd0) && (sum_add >= SW'(clock_rate));
    assign pop_c   = (state == S_RUN) && dma.dma_ack && (dma.dma_req8 || dma.dma_req16);
    assign blk_end_c = pop_c && (count == 16'd0);

    assign dma.dma_writedata = (level != '0) ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next state and datapath strobes
    always_comb begin
        state_next  = state;
        arm_c       = 1'b0;
        flush_c     = 1'b0;
        push_req_c  = 1'b0;
        push_data_c = '0;
        case (state)
            S_IDLE: if (rec_start) state_next = S_ARM;
            S_ARM: begin
                state_next = S_RUN;
                arm_c      = 1'b1;
                flush_c    = 1'b1;
            end
            S_RUN: begin
                // The right channel goes in the cycle after its tick
                if (pend_r) begin
                    push_req_c  = 1'b1;
                    push_data_c = fmt(hold_r, lat_16bit);
                end else if (tick_c) begin
                    push_req_c  = 1'b1;
                    push_data_c = fmt(in_l, lat_16bit);
                end
                if (blk_end_c && !lat_auto) begin
                    state_next = S_IDLE;
                    flush_c    = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (rec_stop) begin
            state_next = S_IDLE;
            flush_c    = 1'b1;
        end
    end

    assign push_c  = push_req_c && !flush_c && ((level != LW'(FIFO_DEPTH)) || pop_c);
    assign drop_c  = push_req_c && !flush_c && (level == LW'(FIFO_DEPTH)) && !pop_c;
    // Request tracks entries still held after this cycle's pop; new pushes show up a cycle later
    assign avail_c = level - LW'(pop_c);
    assign req_c   = (state_next == S_RUN) && !flush_c && (avail_c != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum        <= '0;
            count      <= '0;
            lat_len    <= '0;
            lat_16bit  <= 1'b0;
            lat_stereo <= 1'b0;
            lat_auto   <= 1'b0;
            pend_r     <= 1'b0;
            hold_r     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            irq        <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            dma.dma_req8  <= 1'b0;
            dma.dma_req16 <= 1'b0;
        end else begin
            if (arm_c) begin
                sum        <= '0;
                count      <= rec_len;
                lat_len    <= rec_len;
                lat_16bit  <= rec_16bit;
                lat_stereo <= rec_stereo;
                lat_auto   <= rec_auto;
            end else begin
                if (state == S_RUN) sum <= tick_c ? (sum_add - SW'(clock_rate)) : sum_add;
                if (pop_c) count <= (count == 16'd0) ? lat_len : (count - 16'd1);
            end

            if (flush_c) begin
                pend_r <= 1'b0;
            end else if (state == S_RUN) begin
                pend_r <= tick_c && !pend_r && lat_stereo;
                if (tick_c && !pend_r) hold_r <= in_r;
            end

            if (flush_c) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push_c) - LW'(pop_c);
            end

            if (arm_c)       overrun <= 1'b0;
            else if (drop_c) overrun <= 1'b1;

            irq  <= (irq && !irq_ack) || blk_end_c;
            busy <= (state_next != S_IDLE);
            dma.dma_req8  <= req_c && !lat_16bit;
            dma.dma_req16 <= req_c && lat_16bit;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= push_data_c;
    end
endmodule

// File: doc/sound_dsp_rec.md
Name: sound_dsp_rec

Overview:
- Sound Blaster DSP recording (ADC) path: the reverse of the DSP playback DMA path.
- Samples the line-in/mic input at a programmed rate and formats it as 8- or 16-bit, mono or stereo.
- Buffers samples in a small FIFO and delivers them to memory through the ISA DMA write handshake.
- Raises the DSP IRQ at the end of each block.
- Sits beside the DSP command decoder, which drives its control inputs; its dma_writedata feeds the sound block's DMA write bus.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries (power of 2, 16-bit each).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- clock_rate  in  28  clk frequency in Hz
- rec_start  in  1  one-cycle pulse: begin recording with current settings
- rec_stop  in  1  one-cycle pulse: abort recording
- rec_16bit  in  1  1 = 16-bit signed samples, 0 = 8-bit
- rec_stereo  in  1  1 = capture L then R per tick
- rec_auto  in  1  auto-init block mode
- rec_rate  in  16  sample rate in Hz (per channel)
- rec_len  in  16  block length in DMA transfers minus 1
- in_l  in  16  signed left input sample
- in_r  in  16  signed right input sample
- dma_req8  out  1  8-bit channel request
- dma_req16  out  1  16-bit channel request
- dma_ack  in  1  one-cycle DMA cycle acknowledge
- dma_writedata  out  16  data for memory write
- irq  out  1  block-done interrupt, level
- irq_ack  in  1  one-cycle clear of irq (DSP ack port read)
- busy  out  1  state != IDLE
- overrun  out  1  sticky: sample dropped on full FIFO

Behaviour:
Reset:
- All outputs 0; state IDLE; FIFO empty; accumulator 0.

Rate tick:
- Each clk: sum = sum + rec_rate; if sum >= clock_rate then sum -= clock_rate and tick = 1.
- rec_rate = 0 gives no ticks.

States:
- IDLE --rec_start--> ARM.
- ARM, 1 cycle: flush FIFO, load count = rec_len, clear sum and overrun, latch rec_16bit/rec_stereo/rec_auto/rec_len. Then RUN.
- RUN: on tick, push samples.
  - 16-bit: push in_l; stereo also pushes in_r on the next cycle.
  - 8-bit: byte = in[15:8] ^ 8'h80, pushed as {8'h00, byte}.
  - Input sampled in the tick cycle; for stereo, in_r is latched in the tick cycle too.
- Any state --rec_stop--> IDLE next cycle: FIFO flushed, requests dropped, irq untouched.
- rec_stop wins over rec_start in the same cycle.
- rec_start while not IDLE is ignored.

DMA:
- dma_req8 = RUN & ~16bit & FIFO non-empty; dma_req16 = same with 16bit. Both registered.
- dma_ack while no request is high is ignored.
- On dma_ack: dma_writedata holds FIFO head (valid in the ack cycle; head is combinational), pop, then count -= 1.
- Request deasserts the cycle after the pop that empties the FIFO.
- Push and pop in the same cycle are both performed; level is unchanged.
- Push when full: sample dropped, overrun = 1 (sticky until ARM/reset). A same-cycle pop makes room, so no drop.
- Block end, on the ack with count == 0:
  - irq = 1.
  - If latched auto: count reloads rec_len and RUN continues.
  - Else state goes IDLE, remaining FIFO is flushed, and requests drop next cycle.

IRQ:
- irq_ack clears irq. A set and a clear in the same cycle leaves irq = 1.

Latency:
- Tick to FIFO non-empty is 1 cycle; tick to request is 2 cycles.

Optional Feature:
- Macro SOUND_REC_ROUND_EN.
- Defined: the 8-bit conversion rounds. t = in + 16'h0080, saturating at 16'h7FFF on signed overflow; byte = t[15:8] ^ 8'h80.
- Undefined: truncation as above.
- 16-bit path is unaffected either way.

Test Plan:
- clock_rate=1000, rec_rate=100, mono 8-bit, rec_len=3, in_l=16'h1234, ack 2 cycles after each req -> ticks every 10 clk; 4 transfers of 16'h0092; irq after the 4th ack; busy=0 next cycle; no further req.
- 16-bit stereo, in_l=16'h8001, in_r=16'h7FFF, rec_len=1 -> dma_req16 only; data 8001 then 7FFF; irq after the 2nd ack.
- Auto mode, rec_len=1, acks continue -> irq at transfers 2 and 4; irq_ack after the first clears it; busy stays 1 until rec_stop, then dma_req* = 0 and FIFO empty next cycle.
- No acks for 20 ticks with FIFO_DEPTH=16 -> FIFO holds 16 entries, overrun=1, first entry is the oldest sample; a later rec_start clears overrun.
- irq_ack in the same cycle as the final ack -> irq=1. rec_start and rec_stop in the same cycle from IDLE -> stays IDLE.
- With SOUND_REC_ROUND_EN: in_l=16'h12C0 -> byte 8'h93 (8'h92 without the macro); in_l=16'h7FF0 -> 8'hFF (saturated).
